// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: turns MIPS load/store controls into an SRAM-like
// request/response bus transaction, formats store lanes, extends load data, flags misalignment.
module dmem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [2:0]  fc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        data_req_q, data_req_d;
    logic        data_wr_q, data_wr_d;
    logic [1:0]  data_size_q, data_size_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [3:0]  data_wstrb_q, data_wstrb_d;
    logic [2:0]  fc_q, fc_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_store;
    logic [1:0]  acc_size;
    logic        misaligned;
    logic        start;
    logic [3:0]  fmt_wstrb;
    logic [31:0] fmt_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    // Decode the incoming access and pre-format the store lanes for the bus registers.
    always_comb begin
        is_store = (fc == 3'b101) || (fc == 3'b110) || (fc == 3'b111);
        case (fc)
            3'b000, 3'b001, 3'b101: acc_size = 2'd0;
            3'b010, 3'b011, 3'b110: acc_size = 2'd1;
            default:                acc_size = 2'd2;
        endcase
        misaligned = ((acc_size == 2'd1) && addr[0]) ||
                     ((acc_size == 2'd2) && (addr[1:0] != 2'b00));
        start = (state_q == S_IDLE) && mem_en && !misaligned;
        adel  = (state_q == S_IDLE) && mem_en && misaligned && !is_store;
        ades  = (state_q == S_IDLE) && mem_en && misaligned && is_store;
        stall = start || (state_q == S_REQ) || (state_q == S_WAIT);

        fmt_wstrb = 4'b0000;
        fmt_wdata = 32'h0;
        if (is_store) begin
            case (acc_size)
                2'd0: begin
                    fmt_wstrb = 4'b0001 << addr[1:0];
                    fmt_wdata = {4{wdata[7:0]}};
                end
                2'd1: begin
                    fmt_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                    fmt_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    fmt_wstrb = 4'b1111;
                    fmt_wdata = wdata;
                end
            endcase
        end
    end

    // Load extraction uses the latched address offset, since addr may have moved on.
    always_comb begin
        ld_byte = 8'(data_rdata >> {data_addr_q[1:0], 3'b000});
        ld_half = data_addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (fc_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {24'h0, ld_byte};
            3'b010:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b011:  ld_value = {16'h0, ld_half};
            default: ld_value = data_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        data_req_d   = data_req_q;
        data_wr_d    = data_wr_q;
        data_size_d  = data_size_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_wstrb_d = data_wstrb_q;
        fc_d         = fc_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_REQ;
                    data_req_d   = 1'b1;
                    data_wr_d    = is_store;
                    data_size_d  = acc_size;
                    data_addr_d  = addr;
                    data_wdata_d = fmt_wdata;
                    data_wstrb_d = fmt_wstrb;
                    fc_d         = fc;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    data_req_d = 1'b0;
                    if (data_data_ok) begin
                        state_d = S_DONE;
                        if (!data_wr_q) rdata_d = ld_value;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = S_DONE;
                    if (!data_wr_q) rdata_d = ld_value;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'd0;
            data_addr_q  <= 32'h0;
            data_wdata_q <= 32'h0;
            data_wstrb_q <= 4'b0000;
            fc_q         <= 3'b000;
            rdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            data_req_q   <= data_req_d;
            data_wr_q    <= data_wr_d;
            data_size_q  <= data_size_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_wstrb_q <= data_wstrb_d;
            fc_q         <= fc_d;
            rdata_q      <= rdata_d;
        end
    end

    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_size  = data_size_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;
    assign data_wstrb = data_wstrb_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus random load/store traffic compared
// against an arithmetic model of lane formatting, extension and handshake timing.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [2:0]  fc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_rdata = 32'h0;

    dmem_ctrl dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .fc(fc), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .adel(adel), .ades(ades),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int accessBytes(input logic [2:0] f);
        if (f == 3'd0 || f == 3'd1 || f == 3'd5) return 1;
        if (f == 3'd2 || f == 3'd3 || f == 3'd6) return 2;
        return 4;
    endfunction

    // One complete access with the bus answering addr_ok after aDly wait cycles
    // and data_ok dDly cycles after that (0 = same cycle).
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] bw, input int aDly, input int dDly);
        bit          st;
        int          bytes;
        int          o;
        bit          mis;
        logic [3:0]  eStrb;
        logic [31:0] eWd;
        logic [31:0] v;
        logic [31:0] mask;
        int          reqCnt;
        int          stallCnt;
        st    = (f >= 3'd5);
        bytes = accessBytes(f);
        o     = int'(a[1:0]);
        mis   = (int'(a[1:0]) % bytes) != 0;

        @(negedge clk);
        mem_en = 1'b1; fc = f; addr = a; wdata = wd; data_rdata = bw;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        if (mis) begin
            checkOutput("adel_mis", 32'(adel), 32'(!st));
            checkOutput("ades_mis", 32'(ades), 32'(st));
            checkOutput("stall_mis", 32'(stall), 32'd0);
            @(posedge clk); #1;
            checkOutput("req_mis", 32'(data_req), 32'd0);
            mem_en = 1'b0;
            return;
        end
        checkOutput("stall_idle", 32'(stall), 32'd1);
        checkOutput("adel_ok", 32'({adel, ades}), 32'd0);

        eStrb = st ? 4'(((1 << bytes) - 1) << o) : 4'b0000;
        for (int k = 0; k < 4; k++) eWd[8*k +: 8] = wd[8*(k % bytes) +: 8];

        reqCnt   = 0;
        stallCnt = 1;
        for (int i = 0; i <= aDly; i++) begin
            @(posedge clk); #1;
            reqCnt   += int'(data_req);
            stallCnt += int'(stall);
            checkOutput("req_hi", 32'(data_req), 32'd1);
            checkOutput("wr", 32'(data_wr), 32'(st));
            checkOutput("size", 32'(data_size), (bytes == 1) ? 32'd0 : (bytes == 2) ? 32'd1 : 32'd2);
            checkOutput("baddr", data_addr, a);
            checkOutput("wstrb", 32'(data_wstrb), 32'(eStrb));
            if (st) checkOutput("bwdata", data_wdata, eWd);
            data_addr_ok = (i == aDly);
            data_data_ok = (i == aDly) && (dDly == 0);
        end
        for (int j = 1; j <= dDly; j++) begin
            @(posedge clk); #1;
            data_addr_ok = 1'b0;
            stallCnt += int'(stall);
            checkOutput("req_wait", 32'(data_req), 32'd0);
            data_data_ok = (j == dDly);
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (!st) begin
            v    = bw >> (8 * o);
            mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
            v    = v & mask;
            if ((f == 3'd0 || f == 3'd2) && v[8*bytes-1]) v = v | ~mask;
            model_rdata = v;
        end
        checkOutput("stall_done", 32'(stall), 32'd0);
        checkOutput("req_done", 32'(data_req), 32'd0);
        checkOutput("rdata", rdata, model_rdata);
        checkOutput("req_cycles", 32'(reqCnt), 32'(aDly + 1));
        checkOutput("stall_cycles", 32'(stallCnt), 32'(aDly + dDly + 2));
        mem_en = 1'b0;
        @(posedge clk); #1;
        checkOutput("req_idle", 32'(data_req), 32'd0);
        checkOutput("stall_idle0", 32'(stall), 32'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        int          b;
        rst = 1'b1; mem_en = 1'b0; fc = 3'd0; addr = 32'h0; wdata = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        checkOutput("rst_req", 32'(data_req), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_bus", data_addr | data_wdata | 32'(data_wstrb) | 32'(data_size) | 32'(data_wr), 32'd0);
        checkOutput("rst_rdata", rdata, 32'h0);
        #12 rst = 1'b0;

        // Reset while waiting for data: late response must be dropped.
        @(negedge clk);
        mem_en = 1'b1; fc = 3'd4; addr = 32'h0000_5000; data_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        checkOutput("rw_req", 32'(data_req), 32'd0);
        checkOutput("rw_stall", 32'(stall), 32'd1);
        mem_en = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rw_stall_rst", 32'(stall), 32'd0);
        checkOutput("rw_bus_rst", data_addr | 32'(data_size) | 32'(data_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        data_data_ok = 1'b1;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(posedge clk); #1;
        checkOutput("rw_rdata", rdata, 32'h0);
        checkOutput("rw_req_after", 32'(data_req), 32'd0);

        applyStimulus(3'd0, 32'h0000_1003, 32'h0, 32'h8000_0000, 0, 0);
        applyStimulus(3'd1, 32'h0000_1003, 32'h0, 32'h8000_0000, 0, 0);
        applyStimulus(3'd6, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
        applyStimulus(3'd4, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 3, 2);
        applyStimulus(3'd2, 32'h0000_4001, 32'h0, 32'h0, 0, 0);
        applyStimulus(3'd7, 32'h0000_4002, 32'h0, 32'h0, 0, 0);
        for (int o = 0; o < 4; o++)
            applyStimulus(3'd5, 32'h0000_6000 + 32'(o), 32'h0000_00A5, 32'h0, 1, 1);
        applyStimulus(3'd2, 32'h0000_7002, 32'h0, 32'h9ABC_1234, 0, 1);
        applyStimulus(3'd3, 32'h0000_7002, 32'h0, 32'h9ABC_1234, 1, 0);

        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = accessBytes(f);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'(b * $urandom_range(0, (4 / b) - 1));
            applyStimulus(f, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller in the MEM stage of the MIPS pipeline. It executes the load/store operation selected by the main decoder's `memwrite`/`memtoreg`/`fc` controls over an SRAM-like handshake bus: byte-lane strobes and data replication for stores, sign/zero extension for loads, and misalignment exceptions. It stalls the pipeline until the bus transaction completes.

## Interface
Parameters: none; all widths are fixed at 32-bit MIPS.

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mem_en`  in  1  MEM-stage instruction is a load or store (`memtoreg | memwrite`)
- `fc`  in  3  access code: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- `addr`  in  32  effective address
- `wdata`  in  32  store source (rt)
- `stall`  out  1  freeze pipeline, combinational
- `rdata`  out  32  extended load result, registered
- `adel`  out  1  load address error, combinational
- `ades`  out  1  store address error, combinational
- `data_req`  out  1  bus request
- `data_wr`  out  1  1 = write
- `data_size`  out  2  0 = byte, 1 = half, 2 = word
- `data_addr`  out  32  byte address
- `data_wdata`  out  32  lane-replicated write data
- `data_wstrb`  out  4  byte-lane enables; 0000 on reads
- `data_addr_ok`  in  1  request accepted (valid only while `data_req`)
- `data_data_ok`  in  1  transaction complete
- `data_rdata`  in  32  read word, valid with `data_data_ok`

## Operation
- Access is a store iff `fc[2:0]` ∈ {101,110,111}.
- Misalignment:
  - Half access (LH/LHU/SH) is misaligned when `addr[0]` = 1.
  - Word access (LW/SW) is misaligned when `addr[1:0]` ≠ 00.
  - `adel`/`ades` = `mem_en` & misaligned & (load/store). Asserted only in IDLE.
  - A misaligned access issues no bus request and does not stall.
- Store lanes (o = `addr[1:0]`):
  - SB: wstrb = 0001<<o, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 (o=0) or 1100 (o=2), wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata = wdata.
- Loads: select the byte or half of `data_rdata` by the latched `o`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - The result is written to `rdata` on the `data_data_ok` cycle.
- `data_addr` carries the full byte address, unmodified.
- State machine:
  - IDLE: if `mem_en` & aligned → REQ, latching `fc`, `addr`, and lane-formatted wdata/wstrb into the bus registers, and setting `data_req` = 1.
  - REQ: `data_req` held high with stable fields. On `data_addr_ok`: clear `data_req` → WAIT; if `data_data_ok` is also high in that cycle → DONE (capture rdata).
  - WAIT: on `data_data_ok` → DONE (capture rdata).
  - DONE: one cycle, `stall` = 0 so the pipeline advances → IDLE.
- `stall` = (IDLE & `mem_en` & aligned) | REQ | WAIT.
- `data_data_ok` is ignored in IDLE and DONE. `data_addr_ok` is ignored when `data_req` = 0.

## Timing
- Reset values: state IDLE; `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_wstrb`, `rdata` all 0. `stall`, `adel` and `ades` follow their combinational equations from IDLE.
- Minimum latency, with `addr_ok` and `data_ok` in the same cycle: cycle 0 IDLE (stall=1), cycle 1 REQ, cycle 2 DONE (stall=0, `rdata` valid).
- Each bus wait cycle adds exactly one stall cycle.
- Bus fields stay constant from REQ entry until `data_addr_ok` is sampled.
- `rdata` holds its value until the next completed load. Stores do not modify it.
- Reset mid-operation (REQ/WAIT): immediately returns to IDLE with `data_req` = 0. The pending response is dropped, because the bus shares `rst`.
- Back-to-back accesses: a new access is sampled in IDLE only, so there is no bus request in the DONE cycle.

## Test plan
- LB at 0x1003, bus returns 0x80_00_00_00, `addr_ok` and `data_ok` together → `data_size` 0, `wstrb` 0000, stall for 2 cycles, `rdata` = 0xFFFFFF80. LBU with the same stimulus → `rdata` = 0x00000080.
- SH at 0x2002, wdata 0x1234ABCD → `data_wr` 1, `data_size` 1, `wstrb` 1100, `data_wdata` 0xABCDABCD. `rdata` unchanged.
- LW at 0x3000, `addr_ok` delayed 3 cycles, `data_ok` 2 cycles later → `data_req` high for exactly 4 cycles with stable fields. Stall is low only in the DONE cycle. `rdata` = bus word.
- LH at 0x4001 → `adel` = 1, `stall` = 0, no `data_req`. SW at 0x4002 → `ades` = 1, no request.
- `rst` asserted in WAIT, then a late `data_data_ok` → state IDLE, outputs zero, `rdata` stays 0x00000000.
- SB sweep over offsets 0..3 with wdata 0x000000A5 → `wstrb` 0001/0010/0100/1000, `data_wdata` 0xA5A5A5A5.
